// File: rtl/e_uut_pkg.sv
// Shared constants for the e_uut Option-returning table lookup.
package e_uut_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_W  = 16;

  localparam logic TAG_SOME = 1'b0;
  localparam logic TAG_NONE = 1'b1;

  localparam int unsigned TABLE_DEPTH = 3;
  localparam int unsigned TABLE_INIT [TABLE_DEPTH] = '{11, 12, 13};

  // Entries beyond the supplied initial values read as zero.
  function automatic int unsigned table_init(input int unsigned i);
    table_init = (i < TABLE_DEPTH) ? TABLE_INIT[i] : 0;
  endfunction

endpackage

// File: rtl/e_uut_array_lookup.sv
// Bounds-checked read of a constant table; returns Option tag and payload separately.
module array_lookup #(
  parameter int unsigned DATA_W = e_uut_pkg::DATA_W,
  parameter int unsigned IDX_W  = e_uut_pkg::IDX_W,
  parameter int unsigned DEPTH  = 3
) (
  input  logic [IDX_W-1:0]  index,
  output logic              tag,
  output logic [DATA_W-1:0] payload
);
  import e_uut_pkg::*;

  logic [DATA_W-1:0] tbl [DEPTH];

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_tbl
    assign tbl[g] = DATA_W'(table_init(g));
  end

  // Compare one bit wider than the index so DEPTH == 2**IDX_W still fits.
  localparam logic [IDX_W:0] LIMIT = (IDX_W + 1)'(DEPTH);

  logic in_range;
  assign in_range = ({1'b0, index} < LIMIT);

  always_comb begin
    tag     = TAG_NONE;
    payload = '0;
    if (in_range) begin
      tag = TAG_SOME;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ({1'b0, index} == (IDX_W + 1)'(i)) payload = tbl[i];
      end
    end
  end

endmodule

// File: rtl/e_uut.sv
// Option-encoded constant-table lookup: {tag, payload}, purely combinational.
module e_uut #(
  parameter int unsigned DATA_W = e_uut_pkg::DATA_W,
  parameter int unsigned IDX_W  = e_uut_pkg::IDX_W,
  parameter int unsigned DEPTH  = 3
) (
  input  logic              _i_clk,
  input  logic              _i_rst,
  input  logic [IDX_W-1:0]  _i_index,
  output logic [DATA_W:0]   __output
);
  import e_uut_pkg::*;

  logic              tag;
  logic [DATA_W-1:0] payload;

  array_lookup #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .DEPTH  (DEPTH)
  ) u_lookup (
    .index   (_i_index),
    .tag     (tag),
    .payload (payload)
  );

  assign __output = {tag, payload};

  // Clock and reset are kept for interface compatibility; the block is stateless.
  logic unused_clk_rst;
  assign unused_clk_rst = _i_clk ^ _i_rst;

endmodule

// File: tb/tb_e_uut.sv
// Self-checking bench for e_uut: vector table, corner sequences, random sweep.
module tb_e_uut;

  logic        clk;
  logic        rst;
  logic [15:0] index;
  logic [16:0] out;

  int n_checks;
  int n_fail;

  e_uut #(
    .DATA_W (16),
    .IDX_W  (16),
    .DEPTH  (3)
  ) dut (
    ._i_clk   (clk),
    ._i_rst   (rst),
    ._i_index (index),
    .__output (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: table holds 11, 12, 13; anything else is None (tag 1, payload 0).
  function automatic logic [16:0] model(input logic [15:0] idx);
    int unsigned v;
    v = idx;
    if (v < 3) model = {1'b0, 16'(11 + v)};
    else       model = 17'h10000;
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] idx;
    logic        rst;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{idx: 16'd0,     rst: 1'b1, exp: 17'h0000B};
    vecs[1] = '{idx: 16'd0,     rst: 1'b0, exp: 17'h0000B};
    vecs[2] = '{idx: 16'd1,     rst: 1'b0, exp: 17'h0000C};
    vecs[3] = '{idx: 16'd2,     rst: 1'b0, exp: 17'h0000D};
    vecs[4] = '{idx: 16'd3,     rst: 1'b0, exp: 17'h10000};
    vecs[5] = '{idx: 16'hFFFF,  rst: 1'b0, exp: 17'h10000};
    vecs[6] = '{idx: 16'h0100,  rst: 1'b0, exp: 17'h10000};
    vecs[7] = '{idx: 16'h8001,  rst: 1'b0, exp: 17'h10000};
    vecs[8] = '{idx: 16'h0004,  rst: 1'b1, exp: 17'h10000};
    vecs[9] = '{idx: 16'h0001,  rst: 1'b1, exp: 17'h0000C};

    rst   = 1'b1;
    index = 16'd0;
    #1;
    check("reset_state", out, 17'h0000B);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst   = vecs[i].rst;
      index = vecs[i].idx;
      #1;
      check($sformatf("vec%0d_idx%h", i, vecs[i].idx), out, vecs[i].exp);
    end

    // Consecutive half-cycles: 1 then 2, each settling in the same half-cycle.
    rst = 1'b0;
    @(posedge clk);
    index = 16'd1;
    #1 check("half_cycle_idx1", out, 17'h0000C);
    @(negedge clk);
    index = 16'd2;
    #1 check("half_cycle_idx2", out, 17'h0000D);

    // Reset held three cycles mid-operation must not disturb the output.
    @(negedge clk);
    index = 16'd2;
    rst   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 check($sformatf("rst_hold_c%0d", c), out, 17'h0000D);
    end
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_release", out, 17'h0000D);
    @(posedge clk);
    #1 check("rst_release_edge", out, 17'h0000D);

    // Random sweep, biased toward the small in-range/boundary indices.
    for (int n = 0; n < 1000; n++) begin
      logic [15:0] r;
      if ($urandom_range(0, 3) == 0) r = 16'($urandom_range(0, 5));
      else                           r = 16'($urandom);
      if (n % 2 == 0) @(negedge clk);
      else            @(posedge clk);
      rst   = ($urandom_range(0, 7) == 0);
      index = r;
      #1;
      if ($isunknown(out)) begin
        n_checks++;
        n_fail++;
        $display("FAIL rand_x idx=%h: got %h expected no X", r, out);
      end else begin
        check($sformatf("rand_idx%h", r), out, model(r));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/e_uut.md
E_UUT -- requirements
Module: e_uut

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the payload width.
REQ-002 The block SHALL have parameter IDX_W, default 16, giving the index width.
REQ-003 The block SHALL have parameter DEPTH, default 3, giving the number of table entries.
REQ-004 The block SHALL have port _i_clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port _i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port _i_index, input, IDX_W (16) bits: unsigned element index.
REQ-007 The block SHALL have port __output, output, DATA_W+1 (17) bits: Option-encoded looked-up element.

Function
REQ-008 The block SHALL hold a constant table of DEPTH entries, each DATA_W bits wide: entry 0 = 11, entry 1 = 12, entry 2 = 13.
REQ-009 __output SHALL be encoded as {tag, payload}: bit 16 is the tag, bits 15:0 are the payload.
REQ-010 Tag SHALL be 0 for Some and 1 for None; Some is variant 0.
REQ-011 When _i_index < DEPTH, __output SHALL be {1'b0, table[_i_index]}.
REQ-012 When _i_index >= DEPTH, __output SHALL be {1'b1, 16'h0000}, i.e. 17'h10000.
REQ-013 The index compare SHALL be unsigned across the full IDX_W; no truncation or wrap-around of upper index bits is permitted.
REQ-014 __output SHALL be purely combinational from _i_index, with zero cycles of latency and no dependence on _i_clk.
REQ-015 __output SHALL settle within the same cycle in which _i_index changes.
REQ-016 The block SHALL have no handshake; every index value is accepted unconditionally.
REQ-017 No X SHALL propagate to __output for any fully-defined _i_index.

Reset
REQ-018 The block SHALL contain no state elements; _i_rst SHALL have no effect on __output.
REQ-019 __output SHALL be valid during reset and immediately after release, as a function of _i_index only.
REQ-020 Asserting _i_rst mid-operation SHALL NOT disturb __output.

Structure
REQ-021 A shared package SHALL hold the Option tag constants (TAG_SOME = 0, TAG_NONE = 1), DATA_W, IDX_W, and the table initial-value constants.
REQ-022 The block SHALL use one sub-module, array_lookup, parameterised by DATA_W, IDX_W and DEPTH, performing the bounds check and table read.
REQ-023 array_lookup SHALL output the tag and payload separately; e_uut SHALL concatenate them into __output.

Verification
REQ-024 Index 0 -> __output = 11 (tag 0, payload 11) within the same cycle.
REQ-025 Index 1, then index 2 on consecutive half-cycles -> __output = 12, then 13.
REQ-026 Index 3, and index 16'hFFFF -> __output = 17'h10000 (None) in both cases.
REQ-027 Index 16'h0100 (upper bits set) -> None; this confirms there is no truncation to the low bits.
REQ-028 Hold _i_rst = 1 for 3 cycles while index = 2 -> __output stays 13 throughout, and stays 13 after reset release.
REQ-029 Random sweep of 1000 indices -> __output matches a reference model on every sample, with no X values.
